// File: rtl/mips_pkg.sv
// Shared MIPS constants: register-file geometry and named architectural registers.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package mips_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  // Architectural register numbers used by decode and the controller.
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

  // $0 is hardwired: any logic that writes or forwards must skip it.
  function automatic logic is_zero_reg(input reg_addr_t a);
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/decoder_5_32.sv
// Write-address decoder: wr_addr + enable -> one-hot entry select, bit 0 never set.
// Latency: combinational.
// Backpressure: none.
module decoder_5_32 #(
  parameter int ADDR_W = 5
) (
  input  logic                   ena,
  input  logic [ADDR_W-1:0]      addr,
  output logic [2**ADDR_W-1:0]   sel
);

  // One-hot select; $0 is excluded so its entry can never be written.
  always_comb begin
    sel = '0;
    if (ena && (addr != '0)) begin
      sel[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x N MIPS GPR file, two combinational read ports, one synchronous write port; $0 reads 0.
// Latency: reads 0 cycles, writes visible after one edge (same cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: none; a write is accepted every cycle wr_ena is high.
module register_file
  import mips_pkg::*;
#(
  parameter int N      = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_A,
  input  logic [ADDR_W-1:0] rd_addr_B,
  output logic [N-1:0]      rd_data_A,
  output logic [N-1:0]      rd_data_B,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] wr_sel;
  logic             unused_sel0;

  // Entry 0 has no storage; reads of $0 are forced to zero in the read muxes.
  logic [N-1:0]     mem [1:DEPTH-1];

  logic [N-1:0]     stored_a;
  logic [N-1:0]     stored_b;

  decoder_5_32 #(
    .ADDR_W (ADDR_W)
  ) u_wr_dec (
    .ena  (wr_ena),
    .addr (wr_addr),
    .sel  (wr_sel)
  );

  // Decoder never sets bit 0; it is intentionally left unconsumed.
  assign unused_sel0 = wr_sel[0];

  // Storage update: reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem[i] <= wr_data;
        end
      end
    end
  end

  // Read mux A: $0 always zero, otherwise the stored entry.
  always_comb begin
    stored_a = '0;
    if (rd_addr_A != '0) begin
      stored_a = mem[rd_addr_A];
    end
  end

  // Read mux B: identical to A, fully independent of it.
  always_comb begin
    stored_b = '0;
    if (rd_addr_B != '0) begin
      stored_b = mem[rd_addr_B];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  logic fwd_a;
  logic fwd_b;

  // A write is forwarded only when it will really land: not during reset, never to $0.
  assign wr_live = wr_ena && !rst && (wr_addr != '0);
  assign fwd_a   = wr_live && (wr_addr == rd_addr_A);
  assign fwd_b   = wr_live && (wr_addr == rd_addr_B);

  assign rd_data_A = fwd_a ? wr_data : stored_a;
  assign rd_data_B = fwd_b ? wr_data : stored_b;
`else
  // Without forwarding a same-cycle read sees the old value until the edge.
  assign rd_data_A = stored_a;
  assign rd_data_B = stored_b;
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: scoreboard of expected read values per port.
// Latency: expectations are compared one step after read addresses settle.
// Backpressure: n/a.
module tb_register_file;
  import mips_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        rd_addr_A;
  logic [4:0]        rd_addr_B;
  logic [31:0]       rd_data_A;
  logic [31:0]       rd_data_B;
  logic              wr_ena;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;

  always #5 clk = ~clk;

  register_file #(
    .N      (WORD_W),
    .ADDR_W (REG_ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_A (rd_addr_A),
    .rd_addr_B (rd_addr_B),
    .rd_data_A (rd_data_A),
    .rd_data_B (rd_data_B),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    string       tag;
    bit          port_b;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [REG_COUNT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive read addresses, queue the expected values, then drain against the outputs.
  task automatic expect_rd(input string tag, input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] ea, input logic [31:0] eb);
    sb_t e;
    rd_addr_A = a;
    rd_addr_B = b;
    e.tag = {tag, "_A"}; e.port_b = 1'b0; e.exp = ea; sb_q.push_back(e);
    e.tag = {tag, "_B"}; e.port_b = 1'b1; e.exp = eb; sb_q.push_back(e);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, e.port_b ? rd_data_B : rd_data_A, e.exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_ena  = 1'b0;
  endtask

  initial begin
    logic [4:0]  ra, rb;
    logic [31:0] ea, eb;

    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_A = '0; rd_addr_B = '0;
    tick();
    rst = 1'b0;

    // Reset state: every entry reads zero on both ports.
    for (int i = 0; i < REG_COUNT; i++) begin
      expect_rd($sformatf("rst_r%0d", i), 5'(i), 5'(REG_COUNT - 1 - i), 32'h0, 32'h0);
      tick();
    end

    // Reset clears previously written data.
    write_reg(5'd5, 32'hDEADBEEF);
    expect_rd("pre_clr", 5'd5, REG_ZERO, 32'hDEADBEEF, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_rd("clr", 5'd5, REG_RA, 32'h0, 32'h0);

    // Basic write/read on consecutive edges.
    write_reg(5'd8, 32'h12345678);
    write_reg(5'd9, 32'hCAFEF00D);
    expect_rd("basic", 5'd8, 5'd9, 32'h12345678, 32'hCAFEF00D);

    // $0 immutable, never forwarded.
    wr_ena = 1'b1; wr_addr = REG_ZERO; wr_data = 32'hFFFFFFFF;
    expect_rd("zero_same", REG_ZERO, REG_ZERO, 32'h0, 32'h0);
    tick();
    wr_ena = 1'b0;
    expect_rd("zero_after", REG_ZERO, REG_ZERO, 32'h0, 32'h0);

    // Write-enable gating.
    write_reg(5'd10, 32'h00000001);
    wr_ena = 1'b0; wr_addr = 5'd10; wr_data = 32'hAAAA5555;
    tick(); tick(); tick();
    expect_rd("gate", 5'd10, 5'd10, 32'h00000001, 32'h00000001);

    // Same-cycle read/write of r12.
    write_reg(5'd12, 32'h11111111);
    wr_ena = 1'b1; wr_addr = 5'd12; wr_data = 32'h22222222;
    ea = BYP ? 32'h22222222 : 32'h11111111;
    expect_rd("rw_same", 5'd12, 5'd12, ea, ea);
    tick();
    wr_ena = 1'b0;
    expect_rd("rw_after", 5'd12, 5'd12, 32'h22222222, 32'h22222222);

    // Reset beats a same-cycle write; bypass is off while rst is high.
    write_reg(5'd3, 32'h00000005);
    rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h7;
    expect_rd("rst_wr_same", 5'd3, 5'd3, 32'h00000005, 32'h00000005);
    tick();
    rst = 1'b0; wr_ena = 1'b0;
    expect_rd("rst_wr", 5'd3, 5'd8, 32'h0, 32'h0);

    // Random traffic against a reference model (contents are all zero after the reset above).
    for (int i = 0; i < REG_COUNT; i++) model[i] = 32'h0;
    for (int i = 0; i < 300; i++) begin
      wr_ena  = ($urandom_range(0, 3) != 0);
      wr_addr = 5'($urandom_range(0, REG_COUNT - 1));
      wr_data = $urandom;
      ra = (i % 4 == 0) ? wr_addr : 5'($urandom_range(0, REG_COUNT - 1));
      rb = (i % 5 == 0) ? wr_addr : 5'($urandom_range(0, REG_COUNT - 1));
      ea = (BYP && wr_ena && !is_zero_reg(wr_addr) && wr_addr == ra) ? wr_data : model[ra];
      eb = (BYP && wr_ena && !is_zero_reg(wr_addr) && wr_addr == rb) ? wr_data : model[rb];
      expect_rd($sformatf("rnd%0d", i), ra, rb, ea, eb);
      tick();
      if (wr_ena && !is_zero_reg(wr_addr)) model[wr_addr] = wr_data;
    end
    wr_ena = 1'b0;

    // Final sweep of all entries against the model.
    for (int i = 0; i < REG_COUNT; i++) begin
      expect_rd($sformatf("final_r%0d", i), 5'(i), 5'(i), model[i], model[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
